gjc_ser10: RTL

GJC_SER10 -- requirements
Module: gjc_ser10

---
 rtl/gjc_ser_pkg.sv | 31 +++
 rtl/gjc_ser_skid.sv | 41 ++++
 rtl/gjc_ser10.sv | 83 ++++++++
 3 files changed

// File: rtl/gjc_ser_pkg.sv
// Shared constants, state type and frame builder for the gjc_ser10 serializer.
// Define SER_PARITY_EN to append an even-parity bit to every frame.
package gjc_ser_pkg;

    localparam int WORD_W = 10;
    localparam int CNT_W  = 16;
    localparam int BIT_W  = 4;

`ifdef SER_PARITY_EN
    localparam int FRAME_LEN = 11;
`else
    localparam int FRAME_LEN = 10;
`endif

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    // Bit 0 of the frame goes out first.
    function automatic logic [FRAME_LEN-1:0] build_frame(
        input logic [WORD_W-1:0] w
    );
`ifdef SER_PARITY_EN
        return {^w, w};
`else
        return w;
`endif
    endfunction

endpackage

// File: rtl/gjc_ser_skid.sv
// One-entry pending register in front of the shift register.
// ready_o is high whenever the pending slot is empty.
module gjc_ser_skid
    import gjc_ser_pkg::*;
(
    input  logic              clkGHz,
    input  logic              reset,
    input  logic [WORD_W-1:0] word_i,
    input  logic              valid_i,
    input  logic              pop,
    output logic              ready_o,
    output logic              avail,
    output logic [WORD_W-1:0] word_o
);

    logic              full;
    logic [WORD_W-1:0] data;
    logic              accept;
    logic              direct;

    assign ready_o = ~full;
    assign accept  = valid_i & ~full & ~reset;
    assign avail   = full | accept;
    assign word_o  = full ? data : word_i;

    // An accepted word bypasses the slot when the shifter takes it at once.
    assign direct  = pop & ~full;

    always_ff @(posedge clkGHz) begin
        if (reset) begin
            full <= 1'b0;
            data <= '0;
        end else if (accept && !direct) begin
            full <= 1'b1;
            data <= word_i;
        end else if (pop && full) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/gjc_ser10.sv
// LSB-first 10-bit serializer with gapless back-to-back frames.
// Define SER_PARITY_EN for 11-bit frames carrying an even-parity bit.
module gjc_ser10
    import gjc_ser_pkg::*;
(
    input  logic              clkGHz,
    input  logic              reset,
    input  logic [WORD_W-1:0] word_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              data_o,
    output logic              enable_n,
    output logic [CNT_W-1:0]  words_sent_o
);

    state_t               state;
    state_t               state_nx;
    logic [FRAME_LEN-1:0] shreg;
    logic [BIT_W-1:0]     bitcnt;
    logic [CNT_W-1:0]     sent;
    logic                 avail;
    logic                 take;
    logic                 last;
    logic [WORD_W-1:0]    next_word;

    gjc_ser_skid u_skid (
        .clkGHz  (clkGHz),
        .reset   (reset),
        .word_i  (word_i),
        .valid_i (valid_i),
        .pop     (take),
        .ready_o (ready_o),
        .avail   (avail),
        .word_o  (next_word)
    );

    assign last = (state == SHIFT) &&
                  (bitcnt == BIT_W'(FRAME_LEN - 1));
    assign take = avail && ((state == IDLE) || last);

    always_ff @(posedge clkGHz) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (avail) state_nx = SHIFT;
            SHIFT: if (last && !avail) state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clkGHz) begin
        if (reset) begin
            shreg  <= '0;
            bitcnt <= '0;
            sent   <= '0;
        end else begin
            if (take) begin
                shreg  <= build_frame(next_word);
                bitcnt <= '0;
            end else if (last) begin
                shreg  <= '0;
                bitcnt <= '0;
            end else if (state == SHIFT) begin
                shreg  <= shreg >> 1;
                bitcnt <= bitcnt + BIT_W'(1);
            end
            if (last) begin
                sent <= sent + CNT_W'(1);
            end
        end
    end

    assign data_o       = (state == SHIFT) & shreg[0];
    assign enable_n     = (state != SHIFT);
    assign words_sent_o = sent;

endmodule
